// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// FSM state encoding, datapath select codes and the instruction class record.
package mips_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  // Controller states; the encoding is visible on state_o for debug.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  // ALU function codes (cast to the configured alu_op width at use)
  localparam int unsigned ALU_ADDU = 0;
  localparam int unsigned ALU_SUBU = 1;
  localparam int unsigned ALU_OR   = 2;
  localparam int unsigned ALU_LUI  = 3;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  // Next-PC source
  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_RS  = 2'b11;

  // Register write-back data source
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  // Register write destination
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  // One-hot instruction class; all-zero means illegal.
  typedef struct packed {
    logic addu;
    logic subu;
    logic nop;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
  } iclass_t;

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction classifier: opcode/funct to one-hot class plus an
// illegal flag. jal/jr are only recognised when EN_JAL is set.
module mips_mc_decode
  import mips_pkg::*;
#(
  parameter bit EN_JAL = 1'b1
) (
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output iclass_t    cls_o,
  output logic       illegal_o
);

  iclass_t cls;

  // Classify; anything not matched leaves the class empty and is illegal.
  always_comb begin
    cls = '0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_SLL:  cls.nop  = 1'b1;
          FN_JR:   cls.jr   = EN_JAL;
          default: ;
        endcase
      end
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = EN_JAL;
      OP_BEQ:  cls.beq = 1'b1;
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      default: ;
    endcase
    cls_o     = cls;
    illegal_o = (cls == '0);
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM. Sequences FETCH/DECODE/EXEC/MEM/WB, drives a
// req/ack memory handshake with a wait-cycle timeout, and traps into a sticky
// ERR state on illegal instructions or memory timeout.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8,
  parameter bit EN_JAL  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_iord,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               reg_we,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         ext_op,
  output logic [2:0]         state_o,
  output logic               err
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  iclass_t            cls;
  logic               illegal;
  logic               waiting;
  logic               timed_out;

  // The IR stays stable from DECODE through WB, so decoding it live each
  // cycle is equivalent to latching the class once.
  mips_mc_decode #(.EN_JAL(EN_JAL)) u_decode (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .cls_o     (cls),
    .illegal_o (illegal)
  );

  // Next state and wait counter; an ack on the timeout cycle still completes.
  always_comb begin
    waiting   = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ack;
    timed_out = (TIMEOUT != 0) && waiting && (cnt_q == CNT_W'(TIMEOUT));
    state_d   = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack)        state_d = S_DECODE;
        else if (timed_out) state_d = S_ERR;
      end
      S_DECODE: state_d = illegal ? S_ERR : S_EXEC;
      S_EXEC: begin
        if (cls.lw || cls.sw)                                  state_d = S_MEM;
        else if (cls.addu || cls.subu || cls.ori || cls.lui)   state_d = S_WB;
        else if (cls.beq || cls.j || cls.jal || cls.jr || cls.nop) state_d = S_FETCH;
        else                                                   state_d = S_ERR;
      end
      S_MEM: begin
        if (mem_ack)        state_d = cls.lw ? S_WB : S_FETCH;
        else if (timed_out) state_d = S_ERR;
      end
      S_WB:    state_d = S_FETCH;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    // Count only while still waiting in the same state; saturate so a
    // disabled timeout never wraps into a spurious match.
    if (waiting && (state_d == state_q))
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    else
      cnt_d = '0;
  end

  // State and wait-counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode from the registered state; forced to zero while reset is
  // low so an in-flight request is dropped immediately. The FETCH strobes
  // follow mem_ack so IR/PC load on the completing edge.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_iord = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PCSRC_PC4;
    reg_we   = 1'b0;
    reg_dst  = DST_RT;
    wb_sel   = WB_ALU;
    alu_src  = 1'b0;
    alu_op   = ALUOP_W'(ALU_ADDU);
    ext_op   = EXT_ZERO;
    state_o  = 3'd0;
    err      = 1'b0;
    if (reset) begin
      state_o = state_q;
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ack;
          pc_we   = mem_ack;
        end
        S_EXEC: begin
          if (cls.subu) alu_op = ALUOP_W'(ALU_SUBU);
          if (cls.ori) begin
            alu_src = 1'b1;
            alu_op  = ALUOP_W'(ALU_OR);
          end
          if (cls.lui) begin
            alu_src = 1'b1;
            alu_op  = ALUOP_W'(ALU_LUI);
            ext_op  = EXT_UPPER;
          end
          if (cls.lw || cls.sw) begin
            alu_src = 1'b1;
            ext_op  = EXT_SIGN;
          end
          if (cls.beq) begin
            alu_op = ALUOP_W'(ALU_SUBU);
            pc_we  = zero;
            pc_src = PCSRC_BR;
          end
          if (cls.j || cls.jal) begin
            pc_we  = 1'b1;
            pc_src = PCSRC_JMP;
          end
          if (cls.jal) begin
            reg_we  = 1'b1;
            reg_dst = DST_RA;
            wb_sel  = WB_PC;
          end
          if (cls.jr) begin
            pc_we  = 1'b1;
            pc_src = PCSRC_RS;
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mem_iord = 1'b1;
          mem_we   = cls.sw;
        end
        S_WB: begin
          reg_we = 1'b1;
          if (cls.lw)               wb_sel  = WB_MEM;
          if (cls.addu || cls.subu) reg_dst = DST_RD;
        end
        S_ERR:   err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
